// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD counter/display block: active-low 7-segment patterns,
// BCD digit limit, display polarity, and the digit-to-segment decoder.
package bcd_disp_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Both segment cathodes and digit anodes are driven active-low on the board
    localparam logic ANODE_ON  = 1'b0;
    localparam logic ANODE_OFF = 1'b1;
    localparam logic SEG_LIT   = 1'b0;
    localparam logic SEG_DARK  = 1'b1;

    // {dp,g,f,e,d,c,b,a}; dp stays dark in every pattern
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = {8{SEG_DARK}};

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the ripple increment/decrement chain: carry_in=1 requests a step,
// carry_out=1 signals a 9->0 carry (up) or a 0->9 borrow (down) into the next digit.
module bcd_digit_step
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic       up,
    input  logic       carry_in,
    output logic [3:0] digit_out,
    output logic       carry_out
);

    always_comb begin
        digit_out = digit_in;
        carry_out = 1'b0;
        if (carry_in) begin
            if (up) begin
                if (digit_in >= BCD_MAX) begin
                    digit_out = 4'd0;
                    carry_out = 1'b1;
                end else begin
                    digit_out = digit_in + 4'd1;
                end
            end else begin
                if (digit_in == 4'd0) begin
                    digit_out = BCD_MAX;
                    carry_out = 1'b1;
                end else begin
                    digit_out = digit_in - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with tick prescaler, load, wrap/saturate limits and a
// multiplexed active-low 7-segment driver with optional leading-zero blanking.
module bcd_counter_display
    import bcd_disp_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int SCAN_HZ  = 1000,
    parameter int SATURATE = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                   clk_50MHz,
    input  logic                   reset,
    input  logic                   updown,
    input  logic                   enable,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_value,
    output logic [4*NDIGITS-1:0]   count,
    output logic                   rollover,
    output logic [7:0]             seg,
    output logic [NDIGITS-1:0]     digit
);

    localparam int CW       = 4 * NDIGITS;
    localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
    localparam int SCAN_DIV = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < NDIGITS; i++) begin
            if (v[4*i +: 4] > BCD_MAX) begin
                r[4*i +: 4] = BCD_MAX;
            end
        end
        return r;
    endfunction

    // At a limit, saturating builds keep the current value; wrapping builds take the step
    function automatic logic [CW-1:0] saturate_step(input logic [CW-1:0] cur,
                                                    input logic [CW-1:0] stepped,
                                                    input logic          at_limit);
        return (at_limit && (SATURATE != 0)) ? cur : stepped;
    endfunction

    logic              ud_meta;
    logic              ud_sync;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_p0;
    logic              step_vld_p0;
    logic [CW-1:0]     step_p0;
    logic [NDIGITS:0]  carry_p0;
    logic [CW-1:0]     count_p1;
    logic              rollover_p1;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tick_p0;
    logic [IDX_W-1:0]  scan_idx;
    logic              zero_run_p0;
    logic [NDIGITS-1:0] blank_p0;
    logic [3:0]        nib_sel_p0;
    logic              blank_sel_p0;
    logic [NDIGITS-1:0] anode_p0;
    logic [7:0]        seg_p1;
    logic [NDIGITS-1:0] digit_p1;

    // ---- stage p0: synchroniser, prescaler and combinational step ----
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            ud_meta <= 1'b1;
            ud_sync <= 1'b1;
        end else begin
            ud_meta <= updown;
            ud_sync <= ud_meta;
        end
    end

    assign tick_p0 = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_p0) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign step_vld_p0 = tick_p0 & enable;
    assign carry_p0[0] = 1'b1;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .digit_in  (count_p1[4*g +: 4]),
            .up        (ud_sync),
            .carry_in  (carry_p0[g]),
            .digit_out (step_p0[4*g +: 4]),
            .carry_out (carry_p0[g+1])
        );
    end

    // ---- stage p1: registered count and rollover ----
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            count_p1    <= '0;
            rollover_p1 <= 1'b0;
        end else begin
            rollover_p1 <= 1'b0;
            if (load) begin
                count_p1 <= clamp_bcd(load_value);
            end else if (step_vld_p0) begin
                count_p1    <= saturate_step(count_p1, step_p0, carry_p0[NDIGITS]);
                rollover_p1 <= carry_p0[NDIGITS];
            end
        end
    end

    // ---- stage p0: scan slot timer, blanking and digit select ----
    assign scan_tick_p0 = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
        end else if (scan_tick_p0) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // A digit is blanked when it and every more significant digit are zero
    always_comb begin
        zero_run_p0 = 1'b1;
        blank_p0    = '0;
        for (int i = NDIGITS - 1; i > 0; i--) begin
            zero_run_p0 = zero_run_p0 & (count_p1[4*i +: 4] == 4'd0);
            blank_p0[i] = zero_run_p0 & (BLANK_LZ != 0);
        end
    end

    always_comb begin
        nib_sel_p0   = 4'd0;
        blank_sel_p0 = 1'b0;
        anode_p0     = {NDIGITS{ANODE_OFF}};
        for (int i = 0; i < NDIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                nib_sel_p0   = count_p1[4*i +: 4];
                blank_sel_p0 = blank_p0[i];
                anode_p0[i]  = ANODE_ON;
            end
        end
    end

    // ---- stage p1: display registers, loaded together with the index advance ----
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            scan_idx <= '0;
            seg_p1   <= SEG_OFF;
            digit_p1 <= {NDIGITS{ANODE_OFF}};
        end else if (scan_tick_p0) begin
            seg_p1   <= blank_sel_p0 ? SEG_OFF : seg_decode(nib_sel_p0);
            digit_p1 <= anode_p0;
            scan_idx <= (scan_idx == IDX_W'(NDIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
        end
    end

    assign count    = count_p1;
    assign rollover = rollover_p1;
    assign seg      = seg_p1;
    assign digit    = digit_p1;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench: two instances (wrap + blanking, saturate + no blanking) driven by the
// same stimulus and checked against a decimal-integer reference model of the counter and display.
module tb_bcd_counter_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        updown;
    logic        enable;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count0, count1;
    logic        roll0, roll1;
    logic [7:0]  seg0, seg1;
    logic [3:0]  dig0, dig1;

    always #5 clk = ~clk;

    bcd_counter_display #(
        .NDIGITS(4), .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .SATURATE(0), .BLANK_LZ(1)
    ) dut0 (
        .clk_50MHz(clk), .reset(reset), .updown(updown), .enable(enable), .load(load),
        .load_value(load_value), .count(count0), .rollover(roll0), .seg(seg0), .digit(dig0)
    );

    bcd_counter_display #(
        .NDIGITS(4), .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .SATURATE(1), .BLANK_LZ(0)
    ) dut1 (
        .clk_50MHz(clk), .reset(reset), .updown(updown), .enable(enable), .load(load),
        .load_value(load_value), .count(count1), .rollover(roll1), .seg(seg1), .digit(dig1)
    );

    typedef struct packed {
        logic [15:0] count;
        logic        roll;
        logic [7:0]  seg;
        logic [3:0]  dig;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: cycle index since reset release, scan slot count,
    // counter value as a plain decimal integer, display registers, updown history
    int         k;
    int         slot;
    int         mcount[2];
    logic [7:0] mseg[2];
    logic [3:0] mdig[2];
    logic       ud_d1, ud_d2;
    logic       ud_cur;

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int clamped_value(input logic [15:0] lv);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            int d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    task automatic reset_model();
        k = 0;
        slot = 0;
        ud_d1 = 1'b1;
        ud_d2 = 1'b1;
        for (int n = 0; n < 2; n++) begin
            mcount[n] = 0;
            mseg[n]   = 8'hFF;
            mdig[n]   = 4'hF;
        end
    endtask

    // Expected state of both instances just after the coming rising edge
    task automatic model_and_push(input logic ld, input logic [15:0] lv, input logic ud,
                                  input logic en);
        bit   tick    = (k % 10 == 9);
        bit   scan    = (k % 2 == 1);
        logic ud_used = ud_d2;
        int   idx     = slot % 4;
        for (int n = 0; n < 2; n++) begin
            int   pre = mcount[n];
            int   nxt = pre;
            logic r   = 1'b0;
            bit   sat = (n == 1);
            bit   blk = (n == 0);
            exp_t e;
            if (scan) begin
                mdig[n] = ~(4'b0001 << idx);
                if (blk && idx > 0 && pre < pow10(idx)) mseg[n] = 8'hFF;
                else mseg[n] = seg_of((pre / pow10(idx)) % 10);
            end
            if (ld) begin
                nxt = clamped_value(lv);
            end else if (tick && en) begin
                if (ud_used) begin
                    if (pre == 9999) begin
                        r = 1'b1;
                        nxt = sat ? 9999 : 0;
                    end else nxt = pre + 1;
                end else begin
                    if (pre == 0) begin
                        r = 1'b1;
                        nxt = sat ? 0 : 9999;
                    end else nxt = pre - 1;
                end
            end
            mcount[n] = nxt;
            e.count = to_bcd(nxt);
            e.roll  = r;
            e.seg   = mseg[n];
            e.dig   = mdig[n];
            if (n == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        ud_d2 = ud_d1;
        ud_d1 = ud;
        if (scan) slot++;
        k++;
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic drive_cycle(input logic ld, input logic [15:0] lv, input logic ud,
                               input logic en);
        load       = ld;
        load_value = lv;
        updown     = ud;
        enable     = en;
        model_and_push(ld, lv, ud, en);
        @(negedge clk);
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic        ld;
            logic        en;
            logic [15:0] lv;
            if ($urandom_range(0, 29) == 0) ud_cur = ~ud_cur;
            en = ($urandom_range(0, 7) != 0);
            ld = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       lv = 16'h9997;
                1:       lv = 16'h0002;
                default: lv = 16'($urandom());
            endcase
            drive_cycle(ld, lv, ud_cur, en);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_t want = {16'h0000, 1'b0, 8'hFF, 4'hF};
        exp_t g0   = {count0, roll0, seg0, dig0};
        exp_t g1   = {count1, roll1, seg1, dig1};
        checks++;
        if (g0 !== want) begin
            failures++;
            $display("FAIL %s_dut0 got count=%h roll=%b seg=%h digit=%h expected count=0000 roll=0 seg=ff digit=f",
                     tag, count0, roll0, seg0, dig0);
        end
        checks++;
        if (g1 !== want) begin
            failures++;
            $display("FAIL %s_dut1 got count=%h roll=%b seg=%h digit=%h expected count=0000 roll=0 seg=ff digit=f",
                     tag, count1, roll1, seg1, dig1);
        end
    endtask

    task automatic compare_exp(input int n, input exp_t e, input exp_t g);
        checks++;
        if ({g.count, g.roll} !== {e.count, e.roll}) begin
            failures++;
            $display("FAIL dut%0d_count t=%0t got count=%h roll=%b expected count=%h roll=%b",
                     n, $time, g.count, g.roll, e.count, e.roll);
        end
        checks++;
        if ({g.seg, g.dig} !== {e.seg, e.dig}) begin
            failures++;
            $display("FAIL dut%0d_display t=%0t got seg=%h digit=%h expected seg=%h digit=%h",
                     n, $time, g.seg, g.dig, e.seg, e.dig);
        end
    endtask

    // Monitor: one expectation per rising edge while the counter is out of reset
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) compare_exp(0, q0.pop_front(), {count0, roll0, seg0, dig0});
            if (q1.size() > 0) compare_exp(1, q1.pop_front(), {count1, roll1, seg1, dig1});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        updown     = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        load_value = '0;
        ud_cur     = 1'b1;
        reset_model();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_init");

        @(negedge clk);
        reset = 1'b1;

        // Count up from zero through 0010
        repeat (110) drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1);

        // Upper limit: wrap vs saturate
        drive_cycle(1'b1, 16'h9998, 1'b1, 1'b1);
        repeat (25) drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1);

        // Lower limit: direction settles through the synchroniser before the load
        repeat (2) drive_cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        drive_cycle(1'b1, 16'h0001, 1'b0, 1'b1);
        repeat (25) drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // Nibble clamp on load, held with enable low
        drive_cycle(1'b1, 16'h12AF, 1'b1, 1'b0);
        repeat (12) drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Load on a tick cycle wins over the step, then observe the 0042 scan
        while (k % 10 != 9) drive_cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        drive_cycle(1'b1, 16'h0042, 1'b1, 1'b1);
        repeat (20) drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        random_cycles(3000);

        // Asynchronous reset between clock edges, mid-count and mid-scan
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold");
        reset = 1'b1;
        reset_model();
        ud_cur = 1'b1;
        random_cycles(300);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
